gomoku_move_judge: RTL and testbench
====================================

GOMOKU_MOVE_JUDGE -- requirements
Module: gomoku_move_judge

Interface
REQ-001 SHALL have parameter EDGE_BITS, default 3, meaning log2 of board edge (8x8 board).
REQ-002 SHALL have parameter WIN_LEN, default 5, meaning number of same-colour pieces in a line that wins.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  start/hold request; judging runs while high.
REQ-006 SHALL have port color  input  1  side placing the piece (0 red, 1 green).
REQ-007 SHALL have port pos  input  2*EDGE_BITS  target cell {y,x}.
REQ-008 SHALL have port ram_rd_addr  output  2*EDGE_BITS  board RAM read address {y,x}.
REQ-009 SHALL have port ram_data  input  2  board RAM read data, valid one cycle after address (synchronous read).
REQ-010 SHALL have port result  output  2  verdict: 00 none, 01 valid, 10 invalid (occupied), 11 win.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking result valid.

Function
REQ-012 SHALL use cell codes: 00 empty, 01 red, 10 green; the piece colour code is color ? 10 : 01.
REQ-013 SHALL implement FSM IDLE -> CHECK_OCC -> SCAN -> FINISH -> HOLD -> IDLE.
REQ-014 SHALL leave IDLE on the first cycle en is high, latching color and pos; later changes on color/pos SHALL be ignored until the next start.
REQ-015 CHECK_OCC SHALL drive ram_rd_addr=pos and sample ram_data one cycle later.
REQ-016 If the sampled cell is non-empty, the FSM SHALL go to FINISH with result 10 and SHALL NOT scan.
REQ-017 SCAN SHALL probe 4 axes (horizontal, vertical, diagonal, anti-diagonal), each in both directions.
REQ-018 Each direction SHALL step 1..WIN_LEN-1 cells from pos, 2 cycles per probe (address, then compare).
REQ-019 A direction SHALL stop early at the first non-matching cell or at the board edge.
REQ-020 Coordinates SHALL NOT wrap: a step from x=7 to x=0 (or y) ends that direction with no RAM probe.
REQ-021 Axis count SHALL be 1 + matches(+dir) + matches(-dir), held in a 4-bit counter that cannot overflow.
REQ-022 SCAN SHALL terminate as soon as any axis count >= WIN_LEN (result 11); otherwise, after all axes, the result SHALL be 01.
REQ-023 Worst-case latency from en rise to done SHALL be <= 2 + 8*(WIN_LEN-1)*2 + 2 cycles (68 at WIN_LEN=5).
REQ-024 FINISH SHALL assert done for exactly one cycle; result SHALL then hold its value through HOLD while en stays high.
REQ-025 HOLD SHALL return to IDLE when en is low, and result SHALL return to 00 in that same transition.
REQ-026 If en drops before FINISH, the FSM SHALL abort to IDLE next cycle with done=0 and result=00, with no partial result visible.
REQ-027 ram_rd_addr SHALL be 0 in IDLE and HOLD.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, result=00, done=0, ram_rd_addr=0, all counters and latched inputs=0.
REQ-029 Reset mid-scan SHALL discard the operation; the first cycle after release SHALL be IDLE.

Configuration
REQ-030 The macro GOMOKU_EXACT_FIVE_EN SHALL control overline handling.
REQ-031 With GOMOKU_EXACT_FIVE_EN defined, win SHALL require an axis count == WIN_LEN; an axis count > WIN_LEN (overline) SHALL NOT win.
REQ-032 With GOMOKU_EXACT_FIVE_EN defined, scan depth SHALL extend to WIN_LEN cells per direction so overlines are detected.
REQ-033 Without GOMOKU_EXACT_FIVE_EN, win SHALL be axis count >= WIN_LEN as in REQ-022.

Structure
REQ-034 Package gomoku_pkg SHALL hold the result codes, cell codes and FSM state encoding, shared with the top-level FSM and display scanner.
REQ-035 A sub-module gomoku_ray_stepper SHALL compute the next coordinate and edge-hit flag for a given direction (combinational plus registered step count).

Verification
REQ-036 Scenario: empty board, en with pos=27 color=0 -> done within 68 cycles, result=01.
REQ-037 Scenario: cell 27 holds 10, en pos=27 -> done at cycle 3, result=10, no probes beyond address 27.
REQ-038 Scenario: red at x=1..4 on y=2, place red at (2,0) -> result=11.
REQ-039 Scenario: red at x=6,7 on y=0 and x=0,1 on y=1, place red at (0,5) -> result=01 (no wrap).
REQ-040 Scenario: six red in a row with GOMOKU_EXACT_FIVE_EN defined -> result=01; without it -> result=11.
REQ-041 Scenario: drop en at cycle 10 of scan -> done never pulses and result=00; then rst_n pulsed mid-scan -> state=IDLE.

Source files
------------

// File: rtl/gomoku_pkg.sv
// Shared codes for the gomoku move judge: results, cells, FSM states.
// Also holds the per-direction step deltas used by the ray stepper.
package gomoku_pkg;

  localparam logic [1:0] RES_NONE    = 2'b00;
  localparam logic [1:0] RES_VALID   = 2'b01;
  localparam logic [1:0] RES_INVALID = 2'b10;
  localparam logic [1:0] RES_WIN     = 2'b11;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_RED   = 2'b01;
  localparam logic [1:0] CELL_GREEN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK_OCC,
    S_SCAN,
    S_FINISH,
    S_HOLD
  } state_t;

  // dir[2:1] = axis (h, v, diag, anti-diag), dir[0] = negative side
  function automatic int dir_dx(input logic [2:0] dir);
    int d;
    unique case (dir[2:1])
      2'd0:    d = 1;
      2'd1:    d = 0;
      default: d = 1;
    endcase
    return dir[0] ? -d : d;
  endfunction

  function automatic int dir_dy(input logic [2:0] dir);
    int d;
    unique case (dir[2:1])
      2'd0:    d = 0;
      2'd1:    d = 1;
      2'd2:    d = 1;
      default: d = -1;
    endcase
    return dir[0] ? -d : d;
  endfunction

endpackage

// File: rtl/gomoku_move_judge_if.sv
// Request/verdict and board-RAM signals of the move judge.
// master: requester + RAM side; slave: the judge.
interface gomoku_move_judge_if #(
  parameter int EDGE_BITS = 3
);
  logic                   en;
  logic                   color;
  logic [2*EDGE_BITS-1:0] pos;
  logic [2*EDGE_BITS-1:0] ram_rd_addr;
  logic [1:0]             ram_data;
  logic [1:0]             result;
  logic                   done;

  modport master (
    output en, color, pos, ram_data,
    input  ram_rd_addr, result, done
  );

  modport slave (
    input  en, color, pos, ram_data,
    output ram_rd_addr, result, done
  );
endinterface

// File: rtl/gomoku_ray_stepper.sv
// Next probe cell along one direction from pos, plus off-board flag.
// Ports: i_clr/i_adv control the step count; o_addr/o_edge/o_step out.
module gomoku_ray_stepper
  import gomoku_pkg::*;
#(
  parameter int EDGE_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clr,
  input  logic                   i_adv,
  input  logic [2:0]             i_dir,
  input  logic [2*EDGE_BITS-1:0] i_pos,
  output logic [2*EDGE_BITS-1:0] o_addr,
  output logic                   o_edge,
  output logic [3:0]             o_step
);

  localparam int EDGE = 1 << EDGE_BITS;

  logic [3:0] r_step;
  int         w_k;
  int         w_x;
  int         w_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step <= 4'd0;
    end else if (i_clr) begin
      r_step <= 4'd0;
    end else if (i_adv) begin
      r_step <= r_step + 4'd1;
    end
  end

  // probe k cells out, k = matches so far + 1
  always_comb begin
    w_k = int'(r_step) + 1;
    w_x = int'(i_pos[EDGE_BITS-1:0])
        + dir_dx(i_dir) * w_k;
    w_y = int'(i_pos[2*EDGE_BITS-1:EDGE_BITS])
        + dir_dy(i_dir) * w_k;
  end

  assign o_edge = (w_x < 0) || (w_x >= EDGE)
               || (w_y < 0) || (w_y >= EDGE);
  assign o_addr = {w_y[EDGE_BITS-1:0],
                   w_x[EDGE_BITS-1:0]};
  assign o_step = r_step;

endmodule

// File: rtl/gomoku_move_judge.sv
// Judges a gomoku move: occupancy, then 8-direction line scan.
// Ports: clk, rst_n, bus (slave). Macro GOMOKU_EXACT_FIVE_EN: overline.
module gomoku_move_judge
  import gomoku_pkg::*;
#(
  parameter int EDGE_BITS = 3,
  parameter int WIN_LEN   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  gomoku_move_judge_if.slave bus
);

  localparam int N = 2 * EDGE_BITS;
  localparam logic [3:0] WIN4 = 4'(WIN_LEN);
`ifdef GOMOKU_EXACT_FIVE_EN
  localparam int DEPTH = WIN_LEN;
  localparam bit EARLY = 1'b0;
`else
  localparam int DEPTH = WIN_LEN - 1;
  localparam bit EARLY = 1'b1;
`endif

  function automatic logic is_win(input logic [3:0] c);
`ifdef GOMOKU_EXACT_FIVE_EN
    return c == WIN4;
`else
    return c >= WIN4;
`endif
  endfunction

  state_t     r_state, w_state_n;
  logic       r_phase, w_phase_n;
  logic       r_color;
  logic [N-1:0] r_pos;
  logic [2:0] r_dir, w_dir_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic [1:0] r_result, w_result_n;

  logic       w_step_clr;
  logic       w_step_adv;
  logic       w_dir_done;
  logic [3:0] w_cnt_axis;
  logic [N-1:0] w_probe;
  logic       w_edge;
  logic [3:0] w_step;
  logic [1:0] w_piece;
  logic       w_match;
  logic       w_last;

  gomoku_ray_stepper #(
    .EDGE_BITS (EDGE_BITS)
  ) u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_step_clr),
    .i_adv  (w_step_adv),
    .i_dir  (r_dir),
    .i_pos  (r_pos),
    .o_addr (w_probe),
    .o_edge (w_edge),
    .o_step (w_step)
  );

  assign w_piece = r_color ? CELL_GREEN : CELL_RED;
  assign w_match = (bus.ram_data == w_piece);
  // this match fills the direction's depth
  assign w_last  = (int'(w_step) + 1 >= DEPTH);

  always_comb begin
    w_state_n  = r_state;
    w_phase_n  = r_phase;
    w_dir_n    = r_dir;
    w_cnt_n    = r_cnt;
    w_result_n = r_result;
    w_step_clr = 1'b0;
    w_step_adv = 1'b0;
    w_dir_done = 1'b0;
    w_cnt_axis = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_result_n = RES_NONE;
        w_phase_n  = 1'b0;
        if (bus.en) begin
          w_state_n = S_CHECK_OCC;
        end
      end
      S_CHECK_OCC: begin
        if (!bus.en) begin
          w_state_n = S_IDLE;
          w_phase_n = 1'b0;
        end else if (!r_phase) begin
          w_phase_n = 1'b1;
        end else if (bus.ram_data != CELL_EMPTY) begin
          w_state_n  = S_FINISH;
          w_phase_n  = 1'b0;
          w_result_n = RES_INVALID;
        end else begin
          w_state_n  = S_SCAN;
          w_phase_n  = 1'b0;
          w_dir_n    = 3'd0;
          w_cnt_n    = 4'd1;
          w_step_clr = 1'b1;
        end
      end
      S_SCAN: begin
        if (!bus.en) begin
          w_state_n = S_IDLE;
          w_phase_n = 1'b0;
        end else begin
          if (!r_phase) begin
            if (w_edge) w_dir_done = 1'b1;
            else        w_phase_n  = 1'b1;
          end else if (w_match) begin
            w_cnt_axis = r_cnt + 4'd1;
            w_cnt_n    = w_cnt_axis;
            w_step_adv = 1'b1;
            w_phase_n  = 1'b0;
            if (EARLY && is_win(w_cnt_axis)) begin
              w_state_n  = S_FINISH;
              w_result_n = RES_WIN;
            end else if (w_last) begin
              w_dir_done = 1'b1;
            end
          end else begin
            w_dir_done = 1'b1;
          end
          // + side done: flip to - side; - side done: judge axis
          if (w_dir_done) begin
            w_phase_n  = 1'b0;
            w_step_clr = 1'b1;
            if (!r_dir[0]) begin
              w_dir_n = r_dir + 3'd1;
            end else if (is_win(w_cnt_axis)) begin
              w_state_n  = S_FINISH;
              w_result_n = RES_WIN;
            end else if (r_dir == 3'd7) begin
              w_state_n  = S_FINISH;
              w_result_n = RES_VALID;
            end else begin
              w_dir_n = r_dir + 3'd1;
              w_cnt_n = 4'd1;
            end
          end
        end
      end
      S_FINISH: begin
        w_state_n = S_HOLD;
      end
      S_HOLD: begin
        if (!bus.en) begin
          w_state_n  = S_IDLE;
          w_result_n = RES_NONE;
        end
      end
      default: begin
        w_state_n  = S_IDLE;
        w_result_n = RES_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_phase  <= 1'b0;
      r_color  <= 1'b0;
      r_pos    <= '0;
      r_dir    <= 3'd0;
      r_cnt    <= 4'd0;
      r_result <= RES_NONE;
    end else begin
      r_state  <= w_state_n;
      r_phase  <= w_phase_n;
      r_dir    <= w_dir_n;
      r_cnt    <= w_cnt_n;
      r_result <= w_result_n;
      if (r_state == S_IDLE && bus.en) begin
        r_color <= bus.color;
        r_pos   <= bus.pos;
      end
    end
  end

  always_comb begin
    bus.ram_rd_addr = '0;
    unique case (r_state)
      S_CHECK_OCC: bus.ram_rd_addr = r_pos;
      S_SCAN:      bus.ram_rd_addr = w_edge ? '0 : w_probe;
      default:     bus.ram_rd_addr = '0;
    endcase
  end

  assign bus.done   = (r_state == S_FINISH);
  assign bus.result = r_result;

endmodule

// File: tb/tb_gomoku_move_judge.sv
// Self-checking bench for gomoku_move_judge with a board RAM model
// and a line-length reference judge.
module tb_gomoku_move_judge;
  import gomoku_pkg::*;

`ifdef GOMOKU_EXACT_FIVE_EN
  localparam int DEPTH = 5;
`else
  localparam int DEPTH = 4;
`endif
  localparam int LAT_MAX = 2 + 8 * DEPTH * 2 + 2;
  localparam int LIM = 200;

  logic clk;
  logic rst_n;
  logic [1:0] board [0:63];
  int n_checks;
  int n_fail;

  gomoku_move_judge_if #(.EDGE_BITS(3)) bus();

  gomoku_move_judge #(
    .EDGE_BITS (3),
    .WIN_LEN   (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bus.ram_data <= board[bus.ram_rd_addr];

  function automatic logic [1:0] ref_judge(input int p, input logic c);
    int x, y, len, cx, cy;
    logic [1:0] piece;
    logic win;
    int dxs[4];
    int dys[4];
    dxs = '{1, 0, 1, 1};
    dys = '{0, 1, 1, -1};
    x = p % 8;
    y = p / 8;
    piece = c ? 2'b10 : 2'b01;
    if (board[p] != 2'b00) return 2'b10;
    win = 1'b0;
    for (int a = 0; a < 4; a++) begin
      len = 1;
      for (int s = -1; s <= 1; s += 2) begin
        cx = x + s * dxs[a];
        cy = y + s * dys[a];
        while (cx >= 0 && cx < 8 && cy >= 0 && cy < 8
               && board[cy*8+cx] == piece) begin
          len++;
          cx += s * dxs[a];
          cy += s * dys[a];
        end
      end
`ifdef GOMOKU_EXACT_FIVE_EN
      if (len == 5) win = 1'b1;
`else
      if (len >= 5) win = 1'b1;
`endif
    end
    return win ? 2'b11 : 2'b01;
  endfunction

  task automatic clear_board();
    for (int i = 0; i < 64; i++) board[i] = 2'b00;
  endtask

  task automatic run_move(
    input  logic c, input int p,
    output logic seen, output int cyc,
    output logic [1:0] res, output logic [1:0] res_hold,
    output logic done2, output logic [1:0] res_idle,
    output logic stray);
    @(negedge clk);
    bus.en = 1'b1;
    bus.color = c;
    bus.pos = 6'(p);
    seen = 1'b0;
    stray = 1'b0;
    cyc = 0;
    while (!seen && cyc < LIM) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.color = ~c;
        bus.pos = 6'(p + 9);
      end
      if (bus.ram_rd_addr != 6'd0 && bus.ram_rd_addr != 6'(p))
        stray = 1'b1;
      if (bus.done) seen = 1'b1;
    end
    res = bus.result;
    @(negedge clk);
    done2 = bus.done;
    res_hold = bus.result;
    bus.en = 1'b0;
    @(negedge clk);
    res_idle = bus.result;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.color = 1'b0;
    bus.pos = 6'd0;
    clear_board();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.result !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_result: got %0h expected 0", bus.result);
    end
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %0h expected 0", bus.done);
    end
    n_checks++;
    if (bus.ram_rd_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %0h expected 0", bus.ram_rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_empty();
    logic seen, d2, st;
    int cyc;
    logic [1:0] r, rh, ri;
    clear_board();
    run_move(1'b0, 27, seen, cyc, r, rh, d2, ri, st);
    n_checks++;
    if (seen !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_done: got %0h expected 1 within %0d", seen, LIM);
    end
    n_checks++;
    if (r !== 2'b01) begin
      n_fail++;
      $display("FAIL empty_result: got %0h expected 1", r);
    end
    n_checks++;
    if (cyc > LAT_MAX) begin
      n_fail++;
      $display("FAIL empty_latency: got %0d expected <= %0d", cyc, LAT_MAX);
    end
    n_checks++;
    if (d2 !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got %0h expected 0 on 2nd cycle", d2);
    end
    n_checks++;
    if (rh !== 2'b01) begin
      n_fail++;
      $display("FAIL hold_result: got %0h expected 1", rh);
    end
    n_checks++;
    if (ri !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_result: got %0h expected 0", ri);
    end
  endtask

  task automatic test_occupied();
    logic seen, d2, st;
    int cyc;
    logic [1:0] r, rh, ri;
    clear_board();
    board[27] = 2'b10;
    run_move(1'b0, 27, seen, cyc, r, rh, d2, ri, st);
    n_checks++;
    if (r !== 2'b10) begin
      n_fail++;
      $display("FAIL occ_result: got %0h expected 2", r);
    end
    n_checks++;
    if (cyc !== 3) begin
      n_fail++;
      $display("FAIL occ_latency: got %0d expected 3", cyc);
    end
    n_checks++;
    if (st !== 1'b0) begin
      n_fail++;
      $display("FAIL occ_probe: got stray %0h expected 0", st);
    end
  endtask

  task automatic test_lines();
    logic seen, d2, st;
    int cyc;
    logic [1:0] r, rh, ri, exp6;
    clear_board();
    for (int x = 1; x <= 4; x++) board[2*8+x] = 2'b01;
    run_move(1'b0, 2*8+0, seen, cyc, r, rh, d2, ri, st);
    n_checks++;
    if (r !== 2'b11) begin
      n_fail++;
      $display("FAIL five_row: got %0h expected 3", r);
    end
    clear_board();
    board[6] = 2'b01;
    board[7] = 2'b01;
    board[8] = 2'b01;
    board[9] = 2'b01;
    run_move(1'b0, 5, seen, cyc, r, rh, d2, ri, st);
    n_checks++;
    if (r !== 2'b01) begin
      n_fail++;
      $display("FAIL no_wrap: got %0h expected 1", r);
    end
    clear_board();
    for (int x = 0; x <= 5; x++) if (x != 2) board[3*8+x] = 2'b01;
`ifdef GOMOKU_EXACT_FIVE_EN
    exp6 = 2'b01;
`else
    exp6 = 2'b11;
`endif
    run_move(1'b0, 3*8+2, seen, cyc, r, rh, d2, ri, st);
    n_checks++;
    if (r !== exp6) begin
      n_fail++;
      $display("FAIL overline: got %0h expected %0h", r, exp6);
    end
    clear_board();
    for (int k = 1; k <= 4; k++) board[(7-k)*8+k] = 2'b10;
    run_move(1'b1, 7*8+0, seen, cyc, r, rh, d2, ri, st);
    n_checks++;
    if (r !== 2'b11) begin
      n_fail++;
      $display("FAIL anti_diag_green: got %0h expected 3", r);
    end
  endtask

  task automatic test_abort();
    logic bad;
    clear_board();
    @(negedge clk);
    bus.en = 1'b1;
    bus.pos = 6'd27;
    bus.color = 1'b0;
    repeat (12) @(negedge clk);
    bus.en = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.result !== 2'b00) bad = 1'b1;
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL abort: got leak %0h expected 0", bad);
    end
    @(negedge clk);
    bus.en = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.result !== 2'b00 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_out: got %0h/%0h expected 0/0",
               bus.result, bus.done);
    end
    n_checks++;
    if (bus.ram_rd_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL midrst_addr: got %0h expected 0", bus.ram_rd_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (dut.r_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL midrst_state: got %0d expected IDLE", dut.r_state);
    end
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random();
    logic seen, d2, st, c;
    int cyc, p, v;
    logic [1:0] r, rh, ri, exp_r, mine, other;
    for (int it = 0; it < 40; it++) begin
      c = 1'($urandom_range(0, 1));
      mine = c ? 2'b10 : 2'b01;
      other = c ? 2'b01 : 2'b10;
      for (int i = 0; i < 64; i++) begin
        v = $urandom_range(0, 9);
        board[i] = (v < 5) ? mine : (v < 6) ? other : 2'b00;
      end
      p = $urandom_range(0, 63);
      if ($urandom_range(0, 4) != 0) board[p] = 2'b00;
      exp_r = ref_judge(p, c);
      run_move(c, p, seen, cyc, r, rh, d2, ri, st);
      n_checks++;
      if (r !== exp_r) begin
        n_fail++;
        $display("FAIL rand_result[%0d]: pos %0d got %0h expected %0h",
                 it, p, r, exp_r);
      end
      n_checks++;
      if (!seen || cyc > LAT_MAX) begin
        n_fail++;
        $display("FAIL rand_latency[%0d]: got %0d expected <= %0d",
                 it, cyc, LAT_MAX);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_empty();
    test_occupied();
    test_lines();
    test_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
